x_window_buffer: RTL

X_WINDOW_BUFFER -- requirements
Module: x_window_buffer

---
 rtl/x_window_buffer_if.sv | 30 +++
 rtl/x_window_buffer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/x_window_buffer_if.sv
// Load-side and window-side handshake bundle for x_window_buffer.
// The slave modport is the buffer itself; master is whoever drives it.
interface x_window_buffer_if #(
  parameter int PIX_W    = 8,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int K        = 3,
  parameter int LOAD_PIX = 4
);
  logic                          start;
  logic                          in_valid;
  logic                          in_ready;
  logic [LOAD_PIX*PIX_W-1:0]     in_data;
  logic                          win_valid;
  logic                          win_ready;
  logic [K*K*PIX_W-1:0]          win_data;
  logic [$clog2(IMG_H)-1:0]      win_row;
  logic [$clog2(IMG_W)-1:0]      win_col;
  logic                          frame_done;

  modport master (
    output start, in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_data, win_row, win_col, frame_done
  );

  modport slave (
    input  start, in_valid, in_data, win_ready,
    output in_ready, win_valid, win_data, win_row, win_col, frame_done
  );
endinterface

// File: rtl/x_window_buffer.sv
// Sliding KxK window generator over K+1 rotating zero-padded row buffers.
// One spare row loads ahead while windows of the current row stream out.
module x_window_buffer #(
  parameter int PIX_W    = 8,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int K        = 3,
  parameter int LOAD_PIX = 4
) (
  input logic               clk,
  input logic               rst,
  x_window_buffer_if.slave  bus
);

  localparam int PAD  = (K - 1) / 2;
  localparam int NBUF = K + 1;
  localparam int BW   = IMG_W + 2 * PAD;
  localparam int LPR  = IMG_W / LOAD_PIX;
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int PW   = $clog2(NBUF);
  localparam int XW   = $clog2(BW);
  localparam int LW   = (LPR > 1) ? $clog2(LPR) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [LW-1:0] LD_LAST  = LW'(LPR - 1);
  localparam logic [1:0]    PRE_LAST = 2'(PAD);

  typedef enum logic [1:0] {IDLE, PRELOAD, RUN} state_t;

  state_t state, state_nx;

  logic [PIX_W-1:0] mem [NBUF][BW];
  logic [PW-1:0]    base;
  logic [LW-1:0]    ld_col;
  logic [1:0]       pre_row;
  logic             spare_done;
  logic             row_done;
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic             done_q;

  logic             in_rdy, win_vld;
  logic             load_acc, win_acc;
  logic             row_end, last_win;
  logic             spare_beyond, zero_spare;
  logic             rotate, frame_start;
  logic [PW-1:0]    spare, ld_buf;
  logic [XW-1:0]    wcol;
  logic [K*K*PIX_W-1:0] win;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'((v >= NBUF) ? v - NBUF : v);
  endfunction

  assign frame_start  = (state == IDLE) && bus.start;
  assign spare        = wrap(int'(base) + K);
  assign spare_beyond = (int'(row) + PAD + 1) >= IMG_H;

  assign in_rdy = (state == PRELOAD) ||
                  ((state == RUN) && !spare_done &&
                   !spare_beyond);
  assign win_vld = (state == RUN) && !row_done;

  assign load_acc = bus.in_valid && in_rdy;
  assign win_acc  = win_vld && bus.win_ready;
  assign row_end  = win_acc && (col == COL_LAST);
  assign last_win = row_end && (row == ROW_LAST);

  assign zero_spare = (state == RUN) && !spare_done &&
                      spare_beyond;
  // Rotate as soon as the row is finished and the spare holds row r+PAD+1.
  assign rotate = (state == RUN) && spare_done &&
                  (row_done || (row_end && !last_win));

  assign ld_buf = (state == PRELOAD) ? PW'(PAD + int'(pre_row))
                                     : spare;
  assign wcol   = XW'(PAD) + XW'(ld_col) * XW'(LOAD_PIX);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.start) state_nx = PRELOAD;
      PRELOAD:
        if (load_acc && ld_col == LD_LAST &&
            pre_row == PRE_LAST)
          state_nx = RUN;
      RUN:
        if (last_win) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      base       <= '0;
      ld_col     <= '0;
      pre_row    <= '0;
      spare_done <= 1'b0;
      row_done   <= 1'b0;
      row        <= '0;
      col        <= '0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= last_win;
      if (frame_start) begin
        base       <= '0;
        ld_col     <= '0;
        pre_row    <= '0;
        spare_done <= 1'b0;
        row_done   <= 1'b0;
        row        <= '0;
        col        <= '0;
      end else begin
        if (load_acc) begin
          if (ld_col == LD_LAST) begin
            ld_col <= '0;
            if (state == PRELOAD) pre_row <= pre_row + 2'd1;
            else spare_done <= 1'b1;
          end else begin
            ld_col <= ld_col + 1'b1;
          end
        end
        if (zero_spare) spare_done <= 1'b1;
        if (win_acc) begin
          if (!row_end) begin
            col <= col + 1'b1;
          end else if (last_win) begin
            row <= '0;
            col <= '0;
          end else begin
            row_done <= 1'b1;
          end
        end
        if (rotate) begin
          base       <= wrap(int'(base) + 1);
          row        <= row + 1'b1;
          col        <= '0;
          row_done   <= 1'b0;
          spare_done <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NBUF; b++)
        for (int i = 0; i < BW; i++)
          mem[b][i] <= '0;
    end else if (frame_start) begin
      for (int b = 0; b < NBUF; b++)
        for (int i = 0; i < BW; i++)
          mem[b][i] <= '0;
    end else if (zero_spare) begin
      for (int i = 0; i < BW; i++)
        mem[spare][i] <= '0;
    end else if (load_acc) begin
      for (int p = 0; p < LOAD_PIX; p++)
        mem[ld_buf][wcol + XW'(p)] <=
          bus.in_data[p*PIX_W +: PIX_W];
    end
  end

  always_comb begin
    win = '0;
    for (int k = 0; k < K; k++)
      for (int i = 0; i < K; i++)
        win[(k*K+i)*PIX_W +: PIX_W] =
          mem[wrap(int'(base) + k)][XW'(col) + XW'(i)];
  end

  assign bus.in_ready   = in_rdy;
  assign bus.win_valid  = win_vld;
  assign bus.win_data   = win_vld ? win : '0;
  assign bus.win_row    = row;
  assign bus.win_col    = col;
  assign bus.frame_done = done_q;

endmodule
